m68k_bus_responder: RTL and testbench

- 68000-bus target that answers bus cycles run by another master (Amiga CPU or DMA) into a decoded address window. It is the other end of the FPGA's existing bus-master engine.
- Synchronizes the strobes, decodes the address, hands one word access to an internal register port, then terminates the cycle with nDTACK, or with nBERR on timeout.
- Sits beside the master state machine. It is active only while the FPGA is not bus master.

---
 rtl/m68k_bus_responder_pkg.sv | 42 ++++
 rtl/m68k_bus_responder_bus_sync.sv | 50 +++++
 rtl/m68k_bus_responder.sv | 203 ++++++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m68k_bus_responder_pkg
// Description : Shared definitions for the 68000 bus responder: FSM state
//               encoding, default window constants, strobe bit ordering and
//               the window-decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package m68k_bus_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DELAY = 3'd3,
    ST_TERM  = 3'd4,
    ST_REL   = 3'd5
  } state_e;

  localparam logic [23:0] c_base_addr_def = 24'hE80000;
  localparam int          c_win_bits_def  = 8;

  // Byte-enable ordering {UDS, LDS}
  localparam int c_be_uds = 1;
  localparam int c_be_lds = 0;

  // Bit positions of the control strobes inside the synchronized vector
  localparam int c_sync_w    = 4;
  localparam int c_sync_nas  = 3;
  localparam int c_sync_nuds = 2;
  localparam int c_sync_nlds = 1;
  localparam int c_sync_rnw  = 0;

  // True when byte address addr lies in the 2^win_bits window at base.
  function automatic logic in_window(input logic [23:0] addr,
                                     input logic [23:0] base,
                                     input int          win_bits);
    return (addr >> win_bits) == (base >> win_bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/m68k_bus_responder_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : m68k_bus_responder_bus_sync
// Description : Multi-flop synchronizer for asynchronous bus control bits,
//               followed by a per-bit agree filter: a bit's filtered value
//               only changes when the last two synchronizer stages agree.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               async_in      - raw asynchronous control bits
//               sync_out      - synchronized, skew-filtered control bits
// Revision    : 1.0 - initial release
// ============================================================================
module m68k_bus_responder_bus_sync #(
  parameter int                SYNC_STAGES = 2,
  parameter int                WIDTH       = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= RESET_VAL;
      filt_q <= RESET_VAL;
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      filt_q <= filt_d;
    end
  end

  // Disagreeing bits are mid-transition; keep the previous filtered value.
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < WIDTH; b++) begin
      if (stage_q[SYNC_STAGES-1][b] == stage_q[SYNC_STAGES-2][b])
        filt_d[b] = stage_q[SYNC_STAGES-1][b];
    end
  end

  assign sync_out = filt_d;

endmodule
`default_nettype wire

// File: rtl/m68k_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : m68k_bus_responder
// Description : 68000 bus target. Decodes cycles from another bus master into
//               a window, performs one word access on the register port and
//               terminates with nDTACK (or nBERR on timeout).
// Ports       : sys_clk/sys_rst  - clock, synchronous active-high reset
//               enable           - respond only while FPGA is not bus master
//               nAS/nUDS/nLDS/RnW/A/D _IN - asynchronous bus inputs
//               D_OUT, D_OE, nDTACK_OE, nBERR_OE - bus drive outputs
//               reg_*            - single-access register port
//               busy             - high from ADDR until back in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module m68k_bus_responder
  import m68k_bus_responder_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = c_base_addr_def,
  parameter int          WIN_BITS    = c_win_bits_def,
  parameter int          SYNC_STAGES = 2,
  parameter int          DTACK_DELAY = 0,
  parameter int          TIMEOUT     = 1023
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                enable,
  input  logic                nAS_IN,
  input  logic                nUDS_IN,
  input  logic                nLDS_IN,
  input  logic                RnW_IN,
  input  logic [23:1]         A_IN,
  input  logic [15:0]         D_IN,
  output logic [15:0]         D_OUT,
  output logic [15:0]         D_OE,
  output logic                nDTACK_OE,
  output logic                nBERR_OE,
  output logic                reg_req,
  output logic                reg_we,
  output logic [WIN_BITS-2:0] reg_addr,
  output logic [1:0]          reg_be,
  output logic [15:0]         reg_wdata,
  input  logic [15:0]         reg_rdata,
  input  logic                reg_ack,
  output logic                busy
);

  localparam int CW = 16;

  logic [c_sync_w-1:0] w_sync;
  logic w_nas, w_nuds, w_nlds, w_rnw;

  m68k_bus_responder_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (c_sync_w),
    .RESET_VAL   ('1)
  ) u_bus_sync (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .async_in ({nAS_IN, nUDS_IN, nLDS_IN, RnW_IN}),
    .sync_out (w_sync)
  );

  assign w_nas  = w_sync[c_sync_nas];
  assign w_nuds = w_sync[c_sync_nuds];
  assign w_nlds = w_sync[c_sync_nlds];
  assign w_rnw  = w_sync[c_sync_rnw];

  state_e              state_q,  state_d;
  logic                armed_q,  armed_d;
  logic [CW-1:0]       cnt_q,    cnt_d;
  logic                req_q,    req_d;
  logic                we_q,     we_d;
  logic [WIN_BITS-2:0] addr_q,   addr_d;
  logic [1:0]          be_q,     be_d;
  logic [15:0]         wdata_q,  wdata_d;
  logic [15:0]         dout_q,   dout_d;
  logic                doe_q,    doe_d;
  logic                dtack_q,  dtack_d;
  logic                berr_q,   berr_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    dtack_d = dtack_q;
    berr_d  = berr_q;

    unique case (state_q)
      ST_IDLE: begin
        // A bus cycle is considered only once, on the first sampled-low nAS
        // after nAS was seen high; misses and disabled cycles are consumed.
        if (w_nas) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          if (enable && in_window({A_IN, 1'b0}, BASE_ADDR, WIN_BITS)) begin
            state_d = ST_ADDR;
            addr_d  = A_IN[WIN_BITS-1:1];
            we_d    = ~w_rnw;
          end
        end
      end
      ST_ADDR: begin
        if (w_nas) begin
          state_d = ST_IDLE;
        end else if (!w_nuds || !w_nlds) begin
          be_d[c_be_uds] = ~w_nuds;
          be_d[c_be_lds] = ~w_nlds;
          if (we_q) wdata_d = D_IN;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (reg_ack) begin
          if (!we_q) begin
            dout_d = reg_rdata;
            doe_d  = 1'b1;
          end
          cnt_d   = '0;
          state_d = ST_DELAY;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          berr_d  = 1'b1;
          state_d = ST_TERM;
        end
      end
      ST_DELAY: begin
        if (cnt_q >= CW'(DTACK_DELAY)) begin
          dtack_d = 1'b1;
          state_d = ST_TERM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TERM: begin
        if (w_nas) begin
          doe_d   = 1'b0;
          dtack_d = 1'b0;
          berr_d  = 1'b0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign D_OUT     = dout_q;
  assign D_OE      = {16{doe_q}};
  assign nDTACK_OE = dtack_q;
  assign nBERR_OE  = berr_q;
  assign reg_req   = req_q;
  assign reg_we    = we_q;
  assign reg_addr  = addr_q;
  assign reg_be    = be_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_m68k_bus_responder
// Description : Directed self-checking bench for m68k_bus_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m68k_bus_responder;

  logic        sys_clk = 1'b0;
  logic        sys_rst, enable;
  logic        nAS_IN, nUDS_IN, nLDS_IN, RnW_IN;
  logic [23:1] A_IN;
  logic [15:0] D_IN, D_OUT, D_OE;
  logic        nDTACK_OE, nBERR_OE;
  logic        reg_req, reg_we;
  logic [6:0]  reg_addr;
  logic [1:0]  reg_be;
  logic [15:0] reg_wdata, reg_rdata;
  logic        reg_ack, busy;

  m68k_bus_responder #(
    .BASE_ADDR   (24'hE80000),
    .WIN_BITS    (8),
    .SYNC_STAGES (2),
    .DTACK_DELAY (0),
    .TIMEOUT     (15)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .enable    (enable),
    .nAS_IN    (nAS_IN),
    .nUDS_IN   (nUDS_IN),
    .nLDS_IN   (nLDS_IN),
    .RnW_IN    (RnW_IN),
    .A_IN      (A_IN),
    .D_IN      (D_IN),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .nDTACK_OE (nDTACK_OE),
    .nBERR_OE  (nBERR_OE),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_be    (reg_be),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .busy      (busy)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Cycle counter and passive monitor (sampled on the falling edge)
  int          cyc = 0;
  int          req_cnt, req_cyc, first_doe, first_dtack, first_berr;
  logic        m_we;
  logic [6:0]  m_addr;
  logic [1:0]  m_be;
  logic [15:0] m_wdata;
  bit          any_oe, doe_on_write;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial forever begin
    @(negedge sys_clk);
    if (reg_req) begin
      req_cnt++;
      req_cyc = cyc;
      m_we    = reg_we;
      m_addr  = reg_addr;
      m_be    = reg_be;
      m_wdata = reg_wdata;
    end
    if (D_OE != 16'h0 && first_doe < 0)  first_doe   = cyc;
    if (nDTACK_OE && first_dtack < 0)    first_dtack = cyc;
    if (nBERR_OE && first_berr < 0)      first_berr  = cyc;
    if (D_OE != 16'h0 || nDTACK_OE || nBERR_OE) any_oe = 1'b1;
    if (D_OE != 16'h0 && !RnW_IN) doe_on_write = 1'b1;
  end

  // Register-port model: acks ack_dly cycles after reg_req (negative = never)
  int          ack_dly   = 3;
  logic [15:0] rdata_val = 16'h0;
  initial begin
    reg_ack   = 1'b0;
    reg_rdata = 16'h0;
    forever begin
      @(negedge sys_clk);
      reg_ack = 1'b0;
      if (reg_req && ack_dly >= 0) begin
        repeat (ack_dly) @(negedge sys_clk);
        reg_ack   = 1'b1;
        reg_rdata = rdata_val;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic clear_mon();
    req_cnt = 0; req_cyc = -1; first_doe = -1; first_dtack = -1; first_berr = -1;
    any_oe = 1'b0; doe_on_write = 1'b0;
    m_we = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0;
  endtask

  // One master bus cycle. With expect_term the bench waits (bounded) for
  // nDTACK/nBERR, holds nAS 3 more cycles, then negates and measures release.
  task automatic bus_cycle(input logic [23:0] a, input logic rnw, input logic uds,
                           input logic lds, input logic [15:0] wd, input bit expect_term,
                           output int rel_lat, output logic [15:0] bus_data,
                           output bit term_held);
    int n;
    clear_mon();
    A_IN = a[23:1]; RnW_IN = rnw; D_IN = rnw ? 16'h0 : wd;
    nAS_IN = 1'b0;
    if (!rnw) tick(4);
    nUDS_IN = ~uds; nLDS_IN = ~lds;
    bus_data = 16'h0; term_held = 1'b1;
    if (expect_term) begin
      n = 0;
      while (!(nDTACK_OE || nBERR_OE) && n < 200) begin tick(1); n++; end
      check("term_seen", 32'(n < 200), 32'd1);
      bus_data = D_OUT & D_OE;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        if (!(nDTACK_OE || nBERR_OE)) term_held = 1'b0;
      end
    end else begin
      tick(20);
    end
    nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1; RnW_IN = 1'b1;
    n = 0;
    while ((D_OE != 16'h0 || nDTACK_OE || nBERR_OE) && n < 50) begin tick(1); n++; end
    rel_lat = n;
    tick(4);
  endtask

  int          lat;
  logic [15:0] bdat;
  bit          held;

  initial begin
    sys_rst = 1'b1; enable = 1'b1;
    nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1; RnW_IN = 1'b1;
    A_IN = '0; D_IN = '0;
    clear_mon();
    tick(3);
    // Reset state
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_doe",   32'(D_OE),      32'd0);
    check("rst_dtack", 32'(nDTACK_OE), 32'd0);
    check("rst_berr",  32'(nBERR_OE),  32'd0);
    check("rst_req",   32'(reg_req),   32'd0);
    check("rst_dout",  32'(D_OUT),     32'd0);
    sys_rst = 1'b0;
    tick(3);

    // Read hit 0xE80010 -> word 8, data BEEF, ack 3 cycles after req
    ack_dly = 3; rdata_val = 16'hBEEF;
    bus_cycle(24'hE80010, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, lat, bdat, held);
    check("rd_req_cnt", 32'(req_cnt), 32'd1);
    check("rd_we",      32'(m_we),    32'd0);
    check("rd_addr",    32'(m_addr),  32'd8);
    check("rd_be",      32'(m_be),    32'd3);
    check("rd_data",    32'(bdat),    32'hBEEF);
    check("rd_doe_before_dtack", 32'(first_doe >= 0 && first_doe < first_dtack), 32'd1);
    check("rd_release", 32'(lat <= 4), 32'd1);
    check("rd_no_berr", 32'(first_berr), 32'hFFFF_FFFF);
    check("rd_idle",    32'(busy),    32'd0);

    // Byte write 0xE80021, LDS only, data 00A5
    bus_cycle(24'hE80021, 1'b0, 1'b0, 1'b1, 16'h00A5, 1'b1, lat, bdat, held);
    check("wr_req_cnt", 32'(req_cnt), 32'd1);
    check("wr_we",      32'(m_we),    32'd1);
    check("wr_addr",    32'(m_addr),  32'd16);
    check("wr_be",      32'(m_be),    32'd1);
    check("wr_wdata",   32'(m_wdata), 32'h00A5);
    check("wr_no_doe",  32'(first_doe), 32'hFFFF_FFFF);
    check("wr_dtack_held", 32'(held && first_dtack >= 0), 32'd1);
    check("wr_doe_on_write", 32'(doe_on_write), 32'd0);
    check("wr_release", 32'(lat <= 4), 32'd1);

    // Miss at 0xE90000
    bus_cycle(24'hE90000, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0, lat, bdat, held);
    check("miss_req", 32'(req_cnt), 32'd0);
    check("miss_oe",  32'(any_oe),  32'd0);

    // Timeout: no ack, TIMEOUT=15
    ack_dly = -1;
    bus_cycle(24'hE80040, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, lat, bdat, held);
    check("to_req_cnt",  32'(req_cnt), 32'd1);
    check("to_berr_lat", 32'(first_berr - req_cyc >= 14 && first_berr - req_cyc <= 16), 32'd1);
    check("to_no_dtack", 32'(first_dtack), 32'hFFFF_FFFF);
    check("to_berr_held", 32'(held), 32'd1);
    check("to_release",  32'(lat <= 4), 32'd1);
    ack_dly = 3;

    // nAS negates in ADDR before any data strobe (write cycle, no strobes)
    clear_mon();
    A_IN = 24'hE80030 >> 1; RnW_IN = 1'b0; D_IN = 16'h5555; nAS_IN = 1'b0;
    tick(6);
    nAS_IN = 1'b1; RnW_IN = 1'b1;
    tick(6);
    check("abort_req",  32'(req_cnt), 32'd0);
    check("abort_busy", 32'(busy),    32'd0);
    check("abort_oe",   32'(any_oe),  32'd0);
    rdata_val = 16'h1234;
    bus_cycle(24'hE80002, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, lat, bdat, held);
    check("after_abort_addr", 32'(m_addr), 32'd1);
    check("after_abort_data", 32'(bdat),   32'h1234);

    // Reset during TERM of a read
    clear_mon();
    rdata_val = 16'hCAFE;
    A_IN = 24'hE80008 >> 1; RnW_IN = 1'b1; nAS_IN = 1'b0; nUDS_IN = 1'b0; nLDS_IN = 1'b0;
    begin
      int n = 0;
      while (!nDTACK_OE && n < 200) begin tick(1); n++; end
      check("rst_term_seen", 32'(n < 200), 32'd1);
    end
    sys_rst = 1'b1;
    tick(1);
    check("rstterm_doe",   32'(D_OE),      32'd0);
    check("rstterm_dtack", 32'(nDTACK_OE), 32'd0);
    check("rstterm_berr",  32'(nBERR_OE),  32'd0);
    check("rstterm_idle",  32'(busy),      32'd0);
    sys_rst = 1'b0; enable = 1'b0;
    nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
    tick(5);

    // enable=0: a hit cycle gets no response
    bus_cycle(24'hE80010, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0, lat, bdat, held);
    check("dis_req", 32'(req_cnt), 32'd0);
    check("dis_oe",  32'(any_oe),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
